// File: rtl/rsa_pkg.sv
// Shared types and helpers for the modular-exponentiation core.
// Holds the FSM encoding, exponent-length helper and multiplier timing.
package rsa_pkg;

    localparam int MAXW = 1024;

    // Cycles the Montgomery unit spends after its W iteration cycles.
    localparam int MONT_SUB_CYC = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_LOAD = 3'd2,
        S_MONT = 3'd3,
        S_UPD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Index of the highest set bit plus one; zero when d is zero.
    function automatic logic [10:0] msb_index(
        input logic [MAXW-1:0] d
    );
        logic [10:0] l;
        l = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (d[i]) begin
                l = 11'(i + 1);
            end
        end
        return l;
    endfunction

endpackage

// File: rtl/rsa_modexp_core_mont_mul.sv
// Bit-serial Montgomery product a*b*2^-W mod n, LSB-first over a.
// W iteration cycles, then one cycle with o_done high and o_p valid.
module mont_mul
    import rsa_pkg::*;
#(
    parameter int W  = 256,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_n,
    output logic         o_done,
    output logic [W-1:0] o_p
);

    localparam int LAT = W + MONT_SUB_CYC;
    localparam logic [CW-1:0] LAST = CW'(LAT - 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_n;
    logic [W+1:0]  r_acc;

    logic [W+1:0]  w_s1;
    logic [W+1:0]  w_s2;
    logic [W+1:0]  w_diff;
    logic          w_ge;

    // acc stays below 2n, so acc + b + n never exceeds W+2 bits.
    always_comb begin
        w_s1 = r_acc + (r_a[0] ? {2'b00, r_b} : '0);
        w_s2 = w_s1 + (w_s1[0] ? {2'b00, r_n} : '0);
    end

    assign w_diff = r_acc - {2'b00, r_n};
    assign w_ge   = r_acc >= {2'b00, r_n};
    assign o_p    = W'(w_ge ? w_diff : r_acc);
    assign o_done = r_busy && (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_n    <= '0;
            r_acc  <= '0;
        end else if (i_clr) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_n    <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_a    <= i_a;
            r_b    <= i_b;
            r_n    <= i_n;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end else begin
                r_acc <= w_s2 >> 1;
                r_a   <= r_a >> 1;
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation a^d mod n with valid/ready handshakes and abort.
// Square-and-multiply over Montgomery products; m is kept in normal form.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int W  = 256,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_d,
    input  logic [W-1:0] i_n,
    input  logic         i_abort,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_result,
    output logic         o_err
);

    localparam logic [CW-1:0] PREP_LAST = CW'(W - 1);

    state_t        r_state;
    state_t        w_next;

    logic [W-1:0]  r_t;
    logic [W-1:0]  r_m;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_dsh;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_left;
    logic          r_err;

    logic            w_abort;
    logic            w_illegal;
    logic            w_start;
    logic            w_mdone;
    logic            w_sdone;
    logic [W-1:0]    w_mp;
    logic [W-1:0]    w_sp;
    logic [W-1:0]    w_m_new;
    logic [W-1:0]    w_opm;
    logic [W-1:0]    w_opt;
    logic [W:0]      w_dbl;
    logic [W:0]      w_dsub;
    logic            w_dge;
    logic [W-1:0]    w_t_dbl;
    logic [MAXW-1:0] w_d_ext;
    logic [CW-1:0]   w_l;

    always_comb begin
        w_d_ext        = '0;
        w_d_ext[W-1:0] = i_d;
    end

    assign w_l = CW'(msb_index(w_d_ext));

    // One doubling step of a*2^W mod n.
    always_comb begin
        w_dbl   = {r_t, 1'b0};
        w_dsub  = w_dbl - {1'b0, r_n};
        w_dge   = w_dbl >= {1'b0, r_n};
        w_t_dbl = W'(w_dge ? w_dsub : w_dbl);
    end

    assign w_abort = i_abort
                  && (r_state != S_IDLE)
                  && (r_state != S_DONE);

    assign w_illegal = ~r_n[0]
                    || (r_n == '0)
                    || (r_t >= r_n);

    assign w_m_new = r_dsh[0] ? w_mp : r_m;

    // On restart the multipliers take this cycle's updated m and t.
    assign w_opm = (r_state == S_UPD) ? w_m_new : r_m;
    assign w_opt = (r_state == S_UPD) ? w_sp : r_t;

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_err    = r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == '0
                          && (w_illegal || r_left == '0)) begin
                    w_next = S_DONE;
                end else if (r_cnt == PREP_LAST) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_start = 1'b1;
                    w_next  = S_MONT;
                end
            end
            S_MONT: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_mdone && w_sdone) begin
                    w_next = S_UPD;
                end
            end
            S_UPD: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (r_left == CW'(1)) begin
                    w_next = S_DONE;
                end else begin
                    w_start = 1'b1;
                    w_next  = S_MONT;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_t      <= '0;
            r_m      <= '0;
            r_n      <= '0;
            r_dsh    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_left   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_t    <= i_a;
                        r_n    <= i_n;
                        r_dsh  <= i_d;
                        r_left <= w_l;
                        r_m    <= W'(1);
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (!w_abort) begin
                        if (r_cnt == '0 && w_illegal) begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end else if (r_cnt == '0
                                  && r_left == '0) begin
                            r_result <= (r_n == W'(1)) ? '0 : W'(1);
                        end else begin
                            r_t   <= w_t_dbl;
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_UPD: begin
                    if (!w_abort) begin
                        r_t    <= w_sp;
                        r_m    <= w_m_new;
                        r_dsh  <= r_dsh >> 1;
                        r_left <= r_left - CW'(1);
                        if (r_left == CW'(1)) begin
                            r_result <= w_m_new;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    mont_mul #(
        .W  (W),
        .CW (CW)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_abort),
        .i_start (w_start),
        .i_a     (w_opm),
        .i_b     (w_opt),
        .i_n     (r_n),
        .o_done  (w_mdone),
        .o_p     (w_mp)
    );

    mont_mul #(
        .W  (W),
        .CW (CW)
    ) u_sqr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_abort),
        .i_start (w_start),
        .i_a     (w_opt),
        .i_b     (w_opt),
        .i_n     (r_n),
        .o_done  (w_sdone),
        .o_p     (w_sp)
    );

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core at W=16.
// Vector table plus hold, abort, reset and RSA round-trip sequences.
module tb_rsa_modexp_core;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_d;
    logic [W-1:0] i_n;
    logic         i_abort;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] n;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t vt[15];

    always #5 i_clk = ~i_clk;

    rsa_modexp_core #(
        .W (W)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_d      (i_d),
        .i_n      (i_n),
        .i_abort  (i_abort),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_err    (o_err)
    );

    task automatic chk(input string nm,
                       input longint act,
                       input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] d,
                                   input logic err);
        int l;
        l = 0;
        if (err || d == 16'd0) begin
            return 1;
        end
        for (int i = 0; i < 16; i++) begin
            if (d[i]) l = i + 1;
        end
        return 1 + W + l * (W + 2);
    endfunction

    function automatic logic [15:0] modexp(input logic [15:0] a,
                                           input logic [15:0] d,
                                           input logic [15:0] n);
        longint r;
        longint b;
        r = 1 % longint'(n);
        b = longint'(a) % longint'(n);
        for (int i = 0; i < 16; i++) begin
            if (d[i]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
        end
        return 16'(r);
    endfunction

    task automatic do_req(input logic [15:0] a,
                          input logic [15:0] d,
                          input logic [15:0] n,
                          output logic [15:0] res,
                          output logic err,
                          output int lat);
        chk("ready_at_req", o_ready, 1);
        i_a     = a;
        i_d     = d;
        i_n     = n;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("timeout", 0, 1);
        res = o_result;
        err = o_err;
    endtask

    task automatic release_res();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk("valid_drop", o_valid, 0);
        chk("ready_back", o_ready, 1);
    endtask

    logic [15:0] res;
    logic [15:0] c;
    logic [15:0] x;
    logic        err;
    int          lat;
    bit          seen;

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_abort = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_d     = '0;
        i_n     = '0;

        vt[0]  = '{16'd4,     16'd13,     16'd497,   16'd445,   1'b0};
        vt[1]  = '{16'd7,     16'd0,      16'd11,    16'd1,     1'b0};
        vt[2]  = '{16'd0,     16'd0,      16'd1,     16'd0,     1'b0};
        vt[3]  = '{16'd7,     16'd0,      16'd1,     16'd0,     1'b1};
        vt[4]  = '{16'd5,     16'd3,      16'd10,    16'd0,     1'b1};
        vt[5]  = '{16'd600,   16'd5,      16'd497,   16'd0,     1'b1};
        vt[6]  = '{16'd0,     16'd1,      16'd0,     16'd0,     1'b1};
        vt[7]  = '{16'd2,     16'd10,     16'd1001,  16'd23,    1'b0};
        vt[8]  = '{16'd3,     16'd1,      16'd7,     16'd3,     1'b0};
        vt[9]  = '{16'd65,    16'd17,     16'd3233,  16'd2790,  1'b0};
        vt[10] = '{16'd2790,  16'd2753,   16'd3233,  16'd65,    1'b0};
        vt[11] = '{16'd0,     16'd5,      16'd7,     16'd0,     1'b0};
        vt[12] = '{16'd65534, 16'd3,      16'd65535, 16'd65534, 1'b0};
        vt[13] = '{16'd2,     16'h8000,   16'd65535, 16'd1,     1'b0};
        vt[14] = '{16'd1,     16'hFFFF,   16'd13,    16'd1,     1'b0};

        #12;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_err", o_err, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            do_req(vt[i].a, vt[i].d, vt[i].n, res, err, lat);
            chk($sformatf("v%0d_res", i), res, vt[i].res);
            chk($sformatf("v%0d_err", i), err, vt[i].err);
            chk($sformatf("v%0d_lat", i), lat,
                exp_lat(vt[i].d, vt[i].err));
            release_res();
        end

        // Result held while i_ready is low; abort ignored in S_DONE.
        do_req(16'd4, 16'd13, 16'd497, res, err, lat);
        chk("hold_lat", lat, 89);
        for (int h = 0; h < 5; h++) begin
            i_abort = (h == 2);
            @(posedge i_clk);
            #1;
            chk("hold_valid", o_valid, 1);
            chk("hold_res", o_result, 445);
            chk("hold_ready", o_ready, 0);
        end
        i_abort = 1'b0;
        // A request offered during release must not be taken.
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_a     = 16'd3;
        i_d     = 16'd1;
        i_n     = 16'd7;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("rel_ready", o_ready, 1);
        chk("rel_valid", o_valid, 0);

        // Abort mid-operation, then an immediate new request.
        i_a     = 16'd4;
        i_d     = 16'd13;
        i_n     = 16'd497;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        seen = 1'b0;
        repeat (39) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        i_abort = 1'b1;
        @(posedge i_clk);
        #1;
        i_abort = 1'b0;
        chk("abort_seen", seen, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_ready", o_ready, 1);
        do_req(16'd2, 16'd10, 16'd1001, res, err, lat);
        chk("post_abort_res", res, 23);
        chk("post_abort_lat", lat, 89);
        release_res();

        // Asynchronous reset in the middle of a multiply.
        i_a     = 16'd4;
        i_d     = 16'd13;
        i_n     = 16'd497;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (30) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_ready", o_ready, 1);
        chk("arst_result", o_result, 0);
        chk("arst_err", o_err, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        do_req(16'd4, 16'd13, 16'd497, res, err, lat);
        chk("post_rst_res", res, 445);
        chk("post_rst_lat", lat, 89);
        release_res();

        // RSA round trip with n=3233, e=17, d=2753.
        for (int r = 0; r < 3; r++) begin
            x = 16'($urandom_range(3232, 2));
            do_req(x, 16'd17, 16'd3233, c, err, lat);
            chk("enc_res", c, modexp(x, 16'd17, 16'd3233));
            chk("enc_lat", lat, exp_lat(16'd17, 1'b0));
            release_res();
            do_req(c, 16'd2753, 16'd3233, res, err, lat);
            chk("dec_res", res, x);
            chk("dec_lat", lat, exp_lat(16'd2753, 1'b0));
            release_res();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
Parametrised modular-exponentiation engine computing o_result = i_a^i_d mod i_n for a configurable operand width W. It replaces the fixed 256-bit core: valid/ready handshakes on both sides, abort, input-legality checking, and early termination at the exponent's highest set bit. It sits between the wrapper/IO controller and the key/cipher registers. One engine serves both encrypt and decrypt; the caller selects which by supplying e or d.

Parameters:
W, 256, operand width in bits (modulus, base, exponent, result); legal range 8..1024.
CW, $clog2(W)+1, width of the bit/iteration counters.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_valid  in  1  request valid
o_ready  out  1  engine idle, request accepted when i_valid&&o_ready
i_a  in  W  base (ciphertext/plaintext)
i_d  in  W  exponent
i_n  in  W  modulus
i_abort  in  1  cancel current operation
o_valid  out  1  result valid, held until i_ready
i_ready  in  1  consumer accepts result
o_result  out  W  a^d mod n
o_err  out  1  qualifies o_valid: illegal operands, o_result forced 0

Behaviour:
- Reset: i_rst asynchronous, active-high; clock i_clk. Reset values: o_ready=1, o_valid=0, o_result=0, o_err=0, FSM=S_IDLE, all datapath registers 0.
- Accept: on the edge where i_valid&&o_ready, capture i_a/i_d/i_n; o_ready drops on the next cycle. Inputs are ignored while o_ready=0.
- Legality: error if n[0]==0 (even modulus), a>=n, or n==0. On error, go directly to S_DONE with o_err=1, o_result=0; o_valid rises 1 cycle after accept.
- Trivial case: if d==0 and operands are legal, go to S_DONE with o_result = (n==1)?0:1; o_valid rises 1 cycle after accept.
- L = index of the highest set bit of d, plus 1.
- FSM: S_IDLE -> S_PREP -> S_LOAD -> {S_MONT -> S_UPD} x L -> S_DONE -> S_IDLE.
- S_PREP, W cycles: t = a; each cycle t = 2t, minus n if 2t>=n (W+1-bit compare). Result: t = a*2^W mod n. Also set m=1.
- S_LOAD, 1 cycle: pulse start to both mont_mul instances (m*t and t*t); bit index k=0.
- S_MONT: wait for done, which arrives exactly W+1 cycles after start.
- S_UPD, 1 cycle: always t<=t*t*R^-1; if d[k], m<=m*t*R^-1.
  - If k==L-1: next state S_DONE with o_result<=m.
  - Else: k++ and restart both multipliers in this same cycle.
- Latency: per exponent bit = W+2 cycles. o_valid asserts exactly 1+W+L*(W+2) cycles after the accepting edge (legal, d!=0).
- S_DONE: o_valid=1; o_result/o_err stay stable until i_valid-independent i_ready=1. Then o_valid=0, o_ready=1 on the next cycle. No new accept is possible in the same cycle.
- Abort: i_abort=1 in any state except S_IDLE/S_DONE returns to S_IDLE on the next edge. No o_valid; multipliers are reset synchronously. i_abort is ignored in S_IDLE and S_DONE.
- Simultaneous i_abort and multiplier done in S_MONT: abort wins.
- Widths: internal Montgomery accumulator is W+2 bits (sum of three <2^W terms, pre-shift). Doubling uses W+1 bits. No truncation before the final conditional subtract.
- Reset mid-operation: all state is cleared immediately; o_valid is never glitched high.

Decomposition:
- Package rsa_pkg:
  - state enum (S_IDLE, S_PREP, S_LOAD, S_MONT, S_UPD, S_DONE).
  - function msb_index(d) for L.
  - localparam for the mont_mul latency (W+1).
- Sub-module mont_mul #(W): bit-serial Montgomery product a*b*2^-W mod n, LSB-first.
  - W iteration cycles, then 1 conditional-subtract cycle.
  - o_done is a 1-cycle pulse with o_p valid.
  - Synchronous clear input for abort.
  - Instantiated twice (multiply and square in parallel).

Test Plan:
- W=16, a=4, d=13, n=497 -> o_valid after 1+16+4*18=89 cycles, o_result=445, o_err=0. Hold i_ready=0 for 5 cycles: result stable, o_ready=0.
- W=16, a=7, d=0, n=11 -> o_result=1, o_valid 1 cycle after accept. Same with n=1 -> o_result=0.
- W=16, n=10 (even) or a=600, n=497 -> o_err=1, o_result=0, o_valid 1 cycle after accept, no multiplier activity.
- W=16, a=4, d=13, n=497; i_abort at cycle 40 -> no o_valid. o_ready=1 next cycle. Immediate new request a=2, d=10, n=1001 -> o_result=23.
- W=256 with the lab golden vector (RSA-256 key pair): decrypt(encrypt(x))==x for 3 random x<n. Latency matches the formula with L from d.
- i_rst pulsed asynchronously mid-S_MONT -> outputs return to reset values immediately. The next request completes correctly.
